fnd_scan_capture: RTL and testbench

//  Receive side of the 4-digit FND scan bus: samples the multiplexed common
//  (digit-select) and font (segment) lines produced by the FND scan driver and

---
 rtl/fnd_scan_capture.sv | 178 +++++++++++++++++
 tb/tb_fnd_scan_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_capture.sv
// Receive side of the 4-digit FND scan bus: debounces each digit dwell, decodes the
// seven-segment font and publishes all four digits atomically once per complete frame.
module fnd_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_fnd_com,
  input  logic [7:0]  i_fnd_font,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_frame_done,
  output logic        o_active,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ToW-1:0]   to_cnt_q;
  logic [3:0]       com_q, prev_com_q;
  logic [7:0]       font_q, prev_font_q;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_val_q;
  logic [3:0]       shadow_dp_q;
  logic [3:0]       shadow_blank_q;

  logic             same;
  logic             capture;
  logic             com_ok;
  logic [1:0]       idx;
  logic             font_ok;
  logic             font_blank;
  logic [3:0]       font_val;
  logic [6:0]       pat;
  logic             valid;
  logic             err;
  logic             publish;
  logic             timeout_hit;

  // Dwell tracking: the first sample of a new dwell counts as 1.
  always_comb begin
    same    = ({com_q, font_q} == {prev_com_q, prev_font_q});
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (com_q == 4'hF) begin
      state_d = StWait;
      cnt_d   = '0;
    end else if (!(state_q == StHeld && same)) begin
      if (state_q == StSettle && same) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = CntW'(1);
      end
      if (cnt_d >= CntW'(STABLE_CYCLES)) begin
        capture = 1'b1;
        state_d = StHeld;
      end else begin
        state_d = StSettle;
      end
    end
  end

  always_comb begin
    com_ok = 1'b1;
    idx    = 2'd0;
    unique case (com_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: com_ok = 1'b0;
    endcase
  end

  always_comb begin
    pat        = ~font_q[6:0];
    font_ok    = 1'b1;
    font_blank = 1'b0;
    font_val   = 4'h0;
    case (pat)
      7'h3F: font_val = 4'h0;
      7'h06: font_val = 4'h1;
      7'h5B: font_val = 4'h2;
      7'h4F: font_val = 4'h3;
      7'h66: font_val = 4'h4;
      7'h6D: font_val = 4'h5;
      7'h7D: font_val = 4'h6;
      7'h07: font_val = 4'h7;
      7'h7F: font_val = 4'h8;
      7'h6F: font_val = 4'h9;
      7'h77: font_val = 4'hA;
      7'h7C: font_val = 4'hB;
      7'h39: font_val = 4'hC;
      7'h5E: font_val = 4'hD;
      7'h79: font_val = 4'hE;
      7'h71: font_val = 4'hF;
      7'h00: font_blank = 1'b1;
      default: font_ok = 1'b0;
    endcase
  end

  always_comb begin
    valid       = capture & com_ok & font_ok;
    err         = capture & ~valid;
    publish     = (seen_q == 4'hF);
    timeout_hit = !valid && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    seen_d      = seen_q;
    if (publish)     seen_d = 4'h0;
    if (timeout_hit) seen_d = 4'h0;
    if (valid)       seen_d[idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      com_q          <= 4'hF;
      font_q         <= 8'hFF;
      prev_com_q     <= 4'hF;
      prev_font_q    <= 8'hFF;
      state_q        <= StWait;
      cnt_q          <= '0;
      to_cnt_q       <= '0;
      seen_q         <= 4'h0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= 4'h0;
      shadow_blank_q <= 4'h0;
      o_digits       <= 16'h0;
      o_dp           <= 4'h0;
      o_blank        <= 4'h0;
      o_frame_done   <= 1'b0;
      o_active       <= 1'b0;
      o_err          <= 1'b0;
      o_err_cnt      <= 8'h0;
    end else begin
      com_q       <= i_fnd_com;
      font_q      <= i_fnd_font;
      prev_com_q  <= com_q;
      prev_font_q <= font_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      o_err       <= err;

      if (valid) begin
        shadow_val_q[idx]   <= font_val;
        shadow_dp_q[idx]    <= ~font_q[7];
        shadow_blank_q[idx] <= font_blank;
      end

      if (err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'h1;

      // Counter holds once it reaches the limit; only a valid capture restarts it.
      if (valid) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != ToW'(TIMEOUT_CYCLES)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      o_frame_done <= publish;
      if (publish) begin
        o_digits <= shadow_val_q;
        o_dp     <= shadow_dp_q;
        o_blank  <= shadow_blank_q;
        o_active <= 1'b1;
      end
      if (timeout_hit) o_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fnd_scan_capture.sv
// Directed bench for fnd_scan_capture: normal frames, glitch rejection, bad input
// errors with saturation, timeout, blank/dp decode and mid-frame reset.
module tb_fnd_scan_capture;

  logic        clk;
  logic        reset;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        frame_done;
  logic        active;
  logic        err;
  logic [7:0]  err_cnt;

  int checks_total = 0;
  int checks_pass  = 0;
  int frames       = 0;
  int errs         = 0;
  int f0;
  int e0;

  fnd_scan_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_fnd_com    (fnd_com),
    .i_fnd_font   (fnd_font),
    .o_digits     (digits),
    .o_dp         (dp),
    .o_blank      (blank),
    .o_frame_done (frame_done),
    .o_active     (active),
    .o_err        (err),
    .o_err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors on the inactive edge.
  always @(negedge clk) begin
    if (frame_done) frames <= frames + 1;
    if (err)        errs   <= errs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] com, input logic [7:0] font, input int n);
    fnd_com  = com;
    fnd_font = font;
    step(n);
  endtask

  task automatic frame(input logic [7:0] f0_, input logic [7:0] f1_,
                       input logic [7:0] f2_, input logic [7:0] f3_);
    drive(4'hE, f0_, 8);
    drive(4'hD, f1_, 8);
    drive(4'hB, f2_, 8);
    drive(4'h7, f3_, 8);
    drive(4'hF, 8'hFF, 2);
  endtask

  initial begin
    reset    = 1'b1;
    fnd_com  = 4'hF;
    fnd_font = 8'hFF;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Normal scan 1,2,3,4
    f0 = frames;
    drive(4'hE, 8'hF9, 8);
    drive(4'hD, 8'hA4, 8);
    drive(4'hB, 8'hB0, 8);
    check("scan_no_early_frame", 32'(frames - f0), 32'd0);
    drive(4'h7, 8'h99, 8);
    drive(4'hF, 8'hFF, 2);
    check("scan_frames", 32'(frames - f0), 32'd1);
    check("scan_digits", 32'(digits), 32'h4321);
    check("scan_dp", 32'(dp), 32'h0);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_active", 32'(active), 32'h1);
    check("scan_err_cnt", 32'(err_cnt), 32'h0);

    // Glitch: digit 0 never stable long enough, so the frame cannot complete
    f0 = frames;
    for (int i = 0; i < 6; i++) drive(4'hE, (i % 2 == 0) ? 8'hF9 : 8'hA4, 2);
    drive(4'hD, 8'hA4, 8);
    drive(4'hB, 8'hB0, 8);
    drive(4'h7, 8'h99, 8);
    check("glitch_no_frame", 32'(frames - f0), 32'd0);
    check("glitch_digits_hold", 32'(digits), 32'h4321);
    drive(4'hE, 8'h92, 8);
    check("glitch_frame", 32'(frames - f0), 32'd1);
    check("glitch_digits", 32'(digits), 32'h4325);

    // Bad inputs
    e0 = errs;
    drive(4'hC, 8'hF9, 6);
    check("bad_com_err", 32'(errs - e0), 32'd1);
    check("bad_com_cnt", 32'(err_cnt), 32'd1);
    drive(4'hF, 8'hFF, 2);
    drive(4'hE, 8'hFE, 6);
    check("bad_font_err", 32'(errs - e0), 32'd2);
    check("bad_font_cnt", 32'(err_cnt), 32'd2);
    check("bad_digits_hold", 32'(digits), 32'h4325);
    e0 = errs;
    for (int i = 0; i < 300; i++) drive(4'hC, (i % 2 == 0) ? 8'hF9 : 8'hA4, 6);
    check("sat_err_pulses", 32'(errs - e0), 32'd300);
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    drive(4'hF, 8'hFF, 2);
    check("long_idle_inactive", 32'(active), 32'h0);

    // Timeout
    frame(8'h92, 8'h82, 8'hF8, 8'h80);
    check("to_digits", 32'(digits), 32'h8765);
    check("to_active_pub", 32'(active), 32'h1);
    step(38);
    check("to_active_before", 32'(active), 32'h1);
    step(15);
    check("to_active_after", 32'(active), 32'h0);
    check("to_digits_kept", 32'(digits), 32'h8765);
    frame(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check("to_reactivate", 32'(active), 32'h1);
    check("to_new_digits", 32'(digits), 32'h4321);

    // Blank and decimal points
    frame(8'hF9, 8'hC0, 8'h7F, 8'h19);
    check("bdp_digits", 32'(digits), 32'h4001);
    check("bdp_dp", 32'(dp), 32'hC);
    check("bdp_blank", 32'(blank), 32'h4);

    // Reset mid-frame discards partial frame
    f0 = frames;
    drive(4'hE, 8'h82, 8);
    drive(4'hD, 8'h82, 8);
    drive(4'hB, 8'h82, 8);
    fnd_com  = 4'hF;
    fnd_font = 8'hFF;
    reset    = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    check("mid_rst_digits", 32'(digits), 32'h0);
    check("mid_rst_dp", 32'(dp), 32'h0);
    check("mid_rst_blank", 32'(blank), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    drive(4'h7, 8'h99, 8);
    drive(4'hF, 8'hFF, 4);
    check("mid_rst_no_frame", 32'(frames - f0), 32'd0);
    check("mid_rst_digits_hold", 32'(digits), 32'h0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
